c_element_array: RTL and testbench
==================================

Name: c_element_array

Overview:
- Parametrised, clocked successor to the single Muller C-element.
- Provides LANES independent generalised C-elements. Each lane has NIN inputs, an optional input synchroniser, a glitch/hold filter, per-lane set/clear overrides, and edge-event pulses.
- Used as the completion/join primitive for 4-phase handshake controllers and for multi-source "all agree" detection inside the synchronous core.

Parameters:
- LANES, 4, number of independent C-element lanes (>=1).
- NIN, 2, inputs per lane (>=2).
- SYNC_STAGES, 2, flop stages on every data input (0 = bypass, inputs already synchronous).
- FILTER, 0, extra consecutive cycles the agreement condition must persist before the output flips (0..255).
- INIT, 1'b0, reset value of every lane output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_i  input  LANES*NIN  lane k uses bits [k*NIN +: NIN].
- set_i  input  LANES  per-lane force output to 1 (synchronous).
- clr_i  input  LANES  per-lane force output to 0 (synchronous).
- o  output  LANES  C-element outputs.
- rise_o  output  LANES  one-cycle pulse when o[k] goes 0->1.
- fall_o  output  LANES  one-cycle pulse when o[k] goes 1->0.
- all_o  output  1  1 when every bit of o is 1.
- none_o  output  1  1 when every bit of o is 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n: sampled on the rising edge of clk, no asynchronous path.
- Reset (rst_n=0 at an edge):
  - o = {LANES{INIT}}; rise_o = 0; fall_o = 0.
  - Synchroniser flops cleared to 0.
  - Filter counters cleared to 0.
  - all_o and none_o derived combinationally from o, so they are consistent with o after reset.
- Synchroniser: SYNC_STAGES flops per input bit; s[k] is the synchronised lane vector. SYNC_STAGES=0 means s = in_i directly.
- Per-lane agreement (combinational on s):
  - up = &s[k]
  - dn = ~|s[k]
  - want = (o[k]==0 && up) || (o[k]==1 && dn)
- Per-lane state: the output register plus an 8-bit filter counter cnt[k].
- Lane update priority at each edge, rst_n=1:
  1. clr_i[k]=1 -> o[k]<=0, cnt<=0. clr wins over set when both are asserted.
  2. else set_i[k]=1 -> o[k]<=1, cnt<=0.
  3. else want=0 -> cnt<=0; o holds.
  4. else want=1 and cnt==FILTER -> o[k]<=~o[k], cnt<=0.
  5. else want=1 -> cnt<=cnt+1.
- Hold: the C-element hold property applies. Mixed inputs never change o. Any loss of agreement restarts the filter from 0.
- Latency from the raw input edge making inputs unanimous to the o change: SYNC_STAGES + FILTER + 1 cycles. set_i/clr_i take effect 1 cycle after the sampling edge.
- Edge pulses:
  - rise_o[k] and fall_o[k] are registered and asserted in the same cycle o[k] shows its new value; width exactly 1 cycle.
  - Asserted for any cause of change: C logic, set or clr.
  - No pulse if set/clr leaves o unchanged (e.g. set while already 1).
- Lanes are fully independent; simultaneous events in different lanes are all honoured in the same cycle.
- Reset asserted mid-filter discards the partial count. After reset release, evaluation restarts from the INIT state with empty synchronisers.
- FILTER saturation: cnt never exceeds FILTER, so no wrap. FILTER >= 256 is illegal; an elaboration check fails the build.

Test Plan:
- Basic join: LANES=1, NIN=2, SYNC=0, FILTER=0, INIT=0; in=10 for 5 cycles -> o=0. in=11 -> o=1 on the next edge with rise_o=1 for 1 cycle. in=01 -> o holds 1. in=00 -> o=0 with fall_o pulse.
- Latency: SYNC_STAGES=2, FILTER=3; all inputs go to 1 at cycle 0 -> o rises at cycle 6 exactly. Drop one input at cycle 4 -> counter restarts and o stays 0.
- Override priority: assert set_i and clr_i together with in=11 -> o=0, fall_o pulses only if o was 1. set_i alone while o=1 -> no rise_o pulse.
- Multi-lane and aggregates: LANES=4, drive lanes to 1 on staggered cycles -> all_o=1 only once the last lane rises; none_o=1 only after all lanes fall; independent per-lane rise_o pulses.
- Reset mid-operation: FILTER=5, pull rst_n low after 3 agreeing cycles -> o=INIT and pulses 0 the next edge. After release, 6 fresh agreeing cycles (plus sync stages) are needed before o flips.
- Random stress vs reference model: NIN=3, random inputs/set/clr for 10k cycles -> o, rise_o and fall_o match a cycle-accurate behavioural model every cycle.

Source files
------------

// File: rtl/c_element_array.sv
// c_element_array: LANES independent clocked generalised Muller C-elements.
// Each lane joins NIN inputs. The output switches to 1 once every input is 1
// and switches back to 0 once every input is 0. Mixed inputs hold the output.
// A change of agreement must persist FILTER extra cycles before the output flips.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   in_i    LANES*NIN data inputs, lane k = in_i[k*NIN +: NIN]
//   set_i   per-lane synchronous force-to-1
//   clr_i   per-lane synchronous force-to-0 (wins over set_i)
//   o       lane outputs
//   rise_o  one-cycle pulse in the cycle o[k] first shows 1
//   fall_o  one-cycle pulse in the cycle o[k] first shows 0
//   all_o   every lane output is 1
//   none_o  every lane output is 0

// One C-element lane: output register, filter counter, edge pulses.
module c_element_lane #(
  parameter int   NIN    = 2,
  parameter int   FILTER = 0,
  parameter logic INIT   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIN-1:0] s,
  input  logic           set,
  input  logic           clr,
  output logic           o,
  output logic           rise,
  output logic           fall
);
  localparam logic [7:0] FLT = 8'(FILTER);

  logic [7:0] cnt, cnt_nxt;
  logic       o_nxt;
  logic       want;

  // want: the inputs unanimously disagree with the current output
  assign want = o ? ~|s : &s;

  always_comb begin
    o_nxt   = o;
    cnt_nxt = cnt;
    if (clr) begin
      o_nxt   = 1'b0;
      cnt_nxt = '0;
    end else if (set) begin
      o_nxt   = 1'b1;
      cnt_nxt = '0;
    end else if (!want) begin
      cnt_nxt = '0;
    end else if (cnt == FLT) begin
      o_nxt   = ~o;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o    <= INIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      o    <= o_nxt;
      cnt  <= cnt_nxt;
      // pulses only on a real change, so set/clr that match o give none
      rise <= o_nxt & ~o;
      fall <= ~o_nxt & o;
    end
  end
endmodule

module c_element_array #(
  parameter int   LANES       = 4,
  parameter int   NIN         = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER      = 0,
  parameter logic INIT        = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES*NIN-1:0] in_i,
  input  logic [LANES-1:0]     set_i,
  input  logic [LANES-1:0]     clr_i,
  output logic [LANES-1:0]     o,
  output logic [LANES-1:0]     rise_o,
  output logic [LANES-1:0]     fall_o,
  output logic                 all_o,
  output logic                 none_o
);
  // an 8-bit counter cannot reach FILTER beyond 255
  if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
    $error("c_element_array: FILTER must be in 0..255");
  end

  logic [LANES-1:0][NIN-1:0] s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][LANES*NIN-1:0] sync_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= in_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    c_element_lane #(.NIN(NIN), .FILTER(FILTER), .INIT(INIT)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .s    (s[k]),
      .set  (set_i[k]),
      .clr  (clr_i[k]),
      .o    (o[k]),
      .rise (rise_o[k]),
      .fall (fall_o[k])
    );
  end

  assign all_o  = &o;
  assign none_o = ~|o;
endmodule

// File: tb/tb_c_element_array.sv
// Bench for c_element_array. Instance a: LANES=1 NIN=2 SYNC=0 FILTER=0, driven
// from a vector table. Instance b: LANES=4 NIN=3 SYNC=2 FILTER=3, checked every
// cycle against a behavioural model, plus directed latency/aggregate/reset runs.
module tb_c_element_array;
  localparam int BL = 4, BN = 3, BS = 2, BF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic [1:0] a_in = '0;
  logic [0:0] a_set = '0, a_clr = '0;
  logic [0:0] a_o, a_rise, a_fall;
  logic       a_all, a_none;

  c_element_array #(.LANES(1), .NIN(2), .SYNC_STAGES(0), .FILTER(0), .INIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_i(a_in), .set_i(a_set), .clr_i(a_clr),
    .o(a_o), .rise_o(a_rise), .fall_o(a_fall), .all_o(a_all), .none_o(a_none));

  // instance b
  logic [BL*BN-1:0] b_in = '0;
  logic [BL-1:0]    b_set = '0, b_clr = '0;
  logic [BL-1:0]    b_o, b_rise, b_fall;
  logic             b_all, b_none;

  c_element_array #(.LANES(BL), .NIN(BN), .SYNC_STAGES(BS), .FILTER(BF), .INIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_i(b_in), .set_i(b_set), .clr_i(b_clr),
    .o(b_o), .rise_o(b_rise), .fall_o(b_fall), .all_o(b_all), .none_o(b_none));

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of b: inputs seen BS cycles late (cleared by reset);
  // a lane flips after FILTER+1 consecutive cycles of unanimous disagreement.
  logic [BL*BN-1:0] m_hist [BS];
  logic [BL-1:0]    m_o, m_rise, m_fall;
  int               m_run [BL];

  task automatic model_step();
    logic [BL*BN-1:0] sv;
    logic [BN-1:0]    lv;
    logic             nv;
    if (!rst_n) begin
      m_o = '0; m_rise = '0; m_fall = '0;
      for (int k = 0; k < BL; k++) m_run[k] = 0;
      for (int i = 0; i < BS; i++) m_hist[i] = '0;
    end else begin
      sv = m_hist[BS-1];
      for (int k = 0; k < BL; k++) begin
        lv = sv[k*BN +: BN];
        nv = m_o[k];
        if (b_clr[k]) begin
          nv = 1'b0; m_run[k] = 0;
        end else if (b_set[k]) begin
          nv = 1'b1; m_run[k] = 0;
        end else if ((m_o[k] && lv == '0) || (!m_o[k] && lv == '1)) begin
          m_run[k]++;
          if (m_run[k] > BF) begin nv = ~m_o[k]; m_run[k] = 0; end
        end else begin
          m_run[k] = 0;
        end
        m_rise[k] = nv && !m_o[k];
        m_fall[k] = !nv && m_o[k];
        m_o[k] = nv;
      end
      for (int i = BS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = b_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("b_o", 32'(b_o), 32'(m_o));
    chk("b_rise", 32'(b_rise), 32'(m_rise));
    chk("b_fall", 32'(b_fall), 32'(m_fall));
    chk("b_all", 32'(b_all), 32'(&m_o));
    chk("b_none", 32'(b_none), 32'(~|m_o));
  endtask

  typedef struct {
    logic [1:0] in;
    logic set, clr;
    logic o, rise, fall;
  } vec_t;

  vec_t tbl [19];

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{2'b10, 0, 0, 0, 0, 0};
    tbl[5]  = '{2'b11, 0, 0, 1, 1, 0};
    tbl[6]  = '{2'b11, 0, 0, 1, 0, 0};
    tbl[7]  = '{2'b01, 0, 0, 1, 0, 0};
    tbl[8]  = '{2'b00, 0, 0, 0, 0, 1};
    tbl[9]  = '{2'b00, 0, 0, 0, 0, 0};
    tbl[10] = '{2'b11, 0, 0, 1, 1, 0};
    tbl[11] = '{2'b11, 1, 1, 0, 0, 1};
    tbl[12] = '{2'b11, 1, 1, 0, 0, 0};
    tbl[13] = '{2'b00, 1, 0, 1, 1, 0};
    tbl[14] = '{2'b00, 1, 0, 1, 0, 0};
    tbl[15] = '{2'b00, 0, 0, 0, 0, 1};
    tbl[16] = '{2'b10, 0, 1, 0, 0, 0};
    tbl[17] = '{2'b11, 0, 0, 1, 1, 0};
    tbl[18] = '{2'b11, 1, 0, 1, 0, 0};

    // reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_a_o", 32'(a_o), 0);
    chk("rst_a_pulse", 32'({a_rise, a_fall}), 0);
    chk("rst_a_none", 32'(a_none), 1);
    chk("rst_b_o", 32'(b_o), 0);
    rst_n = 1'b1;

    // table-driven join/override vectors on instance a
    for (int i = 0; i < 19; i++) begin
      a_in = tbl[i].in; a_set[0] = tbl[i].set; a_clr[0] = tbl[i].clr;
      tick();
      chk($sformatf("a_o[%0d]", i), 32'(a_o), 32'(tbl[i].o));
      chk($sformatf("a_rise[%0d]", i), 32'(a_rise), 32'(tbl[i].rise));
      chk($sformatf("a_fall[%0d]", i), 32'(a_fall), 32'(tbl[i].fall));
      chk($sformatf("a_all[%0d]", i), 32'(a_all), 32'(tbl[i].o));
    end
    a_set = '0; a_clr = '0;

    // latency: lanes 0 and 1 unanimous; lane 1 loses agreement before edge 4
    b_in[2:0] = 3'b111; b_in[5:3] = 3'b111;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) b_in[3] = 1'b0;
      tick();
      chk($sformatf("lat_o0[e%0d]", e), 32'(b_o[0]), 32'(e >= BS + BF + 1));
      chk($sformatf("lat_rise0[e%0d]", e), 32'(b_rise[0]), 32'(e == BS + BF + 1));
      chk($sformatf("lat_o1[e%0d]", e), 32'(b_o[1]), 0);
    end
    b_in = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("lat_back_none", 32'(b_none), 1);

    // staggered rise then fall across lanes
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < BL; k++) if (c == 2*k) b_in[k*BN +: BN] = '1;
      tick();
      chk($sformatf("stag_all[c%0d]", c), 32'(b_all), 32'(c >= 2*(BL-1) + 5));
      for (int k = 0; k < BL; k++)
        chk($sformatf("stag_rise%0d[c%0d]", k, c), 32'(b_rise[k]), 32'(c == 2*k + 5));
    end
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < BL; k++) if (c == 2*k) b_in[k*BN +: BN] = '0;
      tick();
      chk($sformatf("stag_none[c%0d]", c), 32'(b_none), 32'(c >= 2*(BL-1) + 5));
      for (int k = 0; k < BL; k++)
        chk($sformatf("stag_fall%0d[c%0d]", k, c), 32'(b_fall[k]), 32'(c == 2*k + 5));
    end

    // reset mid-filter: all lanes forced to 1, inputs 0 agree for 3 counted cycles
    b_in = '1; b_set = '1;
    tick();
    chk("mid_set_rise", 32'(b_rise), 32'hF);
    b_set = '0; b_in = '0;
    for (int i = 0; i < BS + 3; i++) tick();
    chk("mid_still_1", 32'(b_o), 32'hF);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_o", 32'(b_o), 0);
    chk("mid_rst_fall", 32'(b_fall), 0);
    rst_n = 1'b1; b_in = '1;
    for (int e = 1; e <= BS + BF + 1; e++) begin
      tick();
      chk($sformatf("mid_relat[e%0d]", e), 32'(b_o), (e == BS + BF + 1) ? 32'hF : 0);
    end

    // random stress against the model
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < BL; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 2))
            0: b_in[k*BN +: BN] = '1;
            1: b_in[k*BN +: BN] = '0;
            default: b_in[k*BN +: BN] = BN'($urandom);
          endcase
        end
        b_set[k] = ($urandom_range(0, 31) == 0);
        b_clr[k] = ($urandom_range(0, 31) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
